// File: rtl/hex_seq_pkg.sv
// Shared state encoding and rate helper for the hex sequencer control block.
package hex_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_STEP  = 2'd3
    } state_t;

    localparam int unsigned RATE_W  = 2;
    localparam int unsigned LIMIT_W = 16;

    // Prescaler terminal count: 2^(4*rate)-1, i.e. 1/16/256/4096 cycles per advance.
    function automatic logic [LIMIT_W-1:0] rate_limit(input logic [RATE_W-1:0] rate);
        return LIMIT_W'((32'd1 << {rate, 2'b00}) - 32'd1);
    endfunction

endpackage

// File: rtl/hex_seq_ctrl_sync2_edge.sv
// Two-flop synchronizer with a rising-edge detect on the synchronized level.
module sync2_edge (
    input  logic clk,
    input  logic reset_n,
    input  logic d,
    output logic q,
    output logic rise
);

    logic meta;
    logic q_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
            q_d  <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
            q_d  <= q;
        end
    end

    assign rise = q & ~q_d;

endmodule

// File: rtl/hex_seq_ctrl.sv
// Sequence index controller: run/pause/single-step FSM driving a wrapping index
// through a rate prescaler, with wrap pulse and saturating lap count.
module hex_seq_ctrl
    import hex_seq_pkg::*;
#(
    parameter int unsigned DEPTH = 32,
    parameter int unsigned IDX_W = 5,
    parameter int unsigned PRE_W = 12
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             run,
    input  logic             step,
    input  logic             dir,
    input  logic             clr,
    input  logic [1:0]       rate,
    output logic [IDX_W-1:0] index,
    output logic             adv,
    output logic             wrap,
    output logic [7:0]       laps,
    output logic             blank,
    output logic [1:0]       state
);

    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DEPTH - 1);

    logic run_s, step_s, dir_s, clr_s;
    logic run_r, step_r, dir_r, clr_r;
    logic unused_sync;

    sync2_edge u_sync_run  (.clk(clk), .reset_n(reset_n), .d(run),  .q(run_s),  .rise(run_r));
    sync2_edge u_sync_step (.clk(clk), .reset_n(reset_n), .d(step), .q(step_s), .rise(step_r));
    sync2_edge u_sync_dir  (.clk(clk), .reset_n(reset_n), .d(dir),  .q(dir_s),  .rise(dir_r));
    sync2_edge u_sync_clr  (.clk(clk), .reset_n(reset_n), .d(clr),  .q(clr_s),  .rise(clr_r));

    // Only the step edge is consumed; the other detectors stay for uniformity.
    assign unused_sync = run_r ^ dir_r ^ clr_r ^ step_s;

    state_t           st_q, st_d;
    logic [PRE_W-1:0] pre_q, pre_d;
    logic [PRE_W-1:0] limit;
    logic [1:0]       rate_q;
    logic             rate_chg;
    logic             do_adv;
    logic             at_edge;
    logic [IDX_W-1:0] idx_d;

    assign limit    = PRE_W'(rate_limit(rate_q));
    assign rate_chg = (rate_q != rate);

    always_comb begin
        st_d   = st_q;
        pre_d  = pre_q;
        do_adv = 1'b0;
        if (clr_s) begin
            st_d  = ST_IDLE;
            pre_d = '0;
        end else begin
            unique case (st_q)
                ST_IDLE, ST_PAUSE: begin
                    if (run_s) begin
                        st_d = ST_RUN;
                    end else if (step_r) begin
                        st_d = ST_STEP;
                    end
                end
                ST_RUN: begin
                    if (!run_s) begin
                        st_d = ST_PAUSE;
                    end else if (!rate_chg) begin
                        if (pre_q == limit) begin
                            pre_d  = '0;
                            do_adv = 1'b1;
                        end else begin
                            pre_d = pre_q + PRE_W'(1);
                        end
                    end
                end
                ST_STEP: begin
                    do_adv = 1'b1;
                    st_d   = run_s ? ST_RUN : ST_PAUSE;
                end
                default: st_d = ST_IDLE;
            endcase
            // A rate change restarts the count in any state and suppresses that cycle's tick.
            if (rate_chg) begin
                pre_d = '0;
            end
        end
    end

    always_comb begin
        at_edge = dir_s ? (index == IDX_LAST) : (index == '0);
        if (dir_s) begin
            idx_d = at_edge ? '0 : index + IDX_W'(1);
        end else begin
            idx_d = at_edge ? IDX_LAST : index - IDX_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            st_q   <= ST_IDLE;
            pre_q  <= '0;
            rate_q <= '0;
            index  <= '0;
            adv    <= 1'b0;
            wrap   <= 1'b0;
            laps   <= '0;
        end else begin
            st_q   <= st_d;
            pre_q  <= pre_d;
            rate_q <= rate;
            adv    <= do_adv;
            wrap   <= do_adv & at_edge;
            if (clr_s) begin
                index <= '0;
                laps  <= '0;
            end else if (do_adv) begin
                index <= idx_d;
                if (at_edge && (laps != 8'hFF)) begin
                    laps <= laps + 8'd1;
                end
            end
        end
    end

    assign blank = (st_q == ST_IDLE);
    assign state = st_q;

endmodule

// File: tb/tb_hex_seq_ctrl.sv
// Self-checking bench for hex_seq_ctrl: scoreboard of expected index/wrap per advance.
module tb_hex_seq_ctrl;

    localparam int unsigned DEPTH = 32;
    localparam int unsigned IDX_W = 5;
    localparam int unsigned PRE_W = 12;

    logic             clk     = 1'b0;
    logic             reset_n = 1'b0;
    logic             run     = 1'b0;
    logic             step    = 1'b0;
    logic             dir     = 1'b1;
    logic             clr     = 1'b0;
    logic [1:0]       rate    = 2'd0;
    logic [IDX_W-1:0] index;
    logic             adv;
    logic             wrap;
    logic [7:0]       laps;
    logic             blank;
    logic [1:0]       state;

    typedef struct packed {
        logic [IDX_W-1:0] idx;
        logic             wr;
    } exp_t;

    exp_t             sb[$];
    logic [IDX_W-1:0] m_idx = '0;
    int               n_cmp = 0;
    int               n_bad = 0;
    int               cyc   = 0;

    hex_seq_ctrl #(.DEPTH(DEPTH), .IDX_W(IDX_W), .PRE_W(PRE_W)) dut (
        .clk(clk), .reset_n(reset_n), .run(run), .step(step), .dir(dir), .clr(clr),
        .rate(rate), .index(index), .adv(adv), .wrap(wrap), .laps(laps),
        .blank(blank), .state(state)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic exp_t model_next(input logic [IDX_W-1:0] cur, input logic up);
        exp_t e;
        logic [IDX_W-1:0] last;
        last = IDX_W'(DEPTH - 1);
        if (up) begin
            e.wr  = (cur == last);
            e.idx = e.wr ? '0 : IDX_W'(cur + 1);
        end else begin
            e.wr  = (cur == '0);
            e.idx = e.wr ? last : IDX_W'(cur - 1);
        end
        return e;
    endfunction

    task automatic push_adv(input int n, input logic up);
        exp_t e;
        for (int k = 0; k < n; k++) begin
            e = model_next(m_idx, up);
            m_idx = e.idx;
            sb.push_back(e);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0; run = 1'b0; step = 1'b0; dir = 1'b1; clr = 1'b0; rate = 2'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_cmp++; if (index !== '0)    begin n_bad++; $display("FAIL reset_index: got %0d expected 0", index); end
        n_cmp++; if (adv !== 1'b0 || wrap !== 1'b0) begin n_bad++; $display("FAIL reset_pulses: got adv=%b wrap=%b expected 0/0", adv, wrap); end
        n_cmp++; if (laps !== 8'd0)   begin n_bad++; $display("FAIL reset_laps: got %0d expected 0", laps); end
        n_cmp++; if (blank !== 1'b1)  begin n_bad++; $display("FAIL reset_blank: got %b expected 1", blank); end
        n_cmp++; if (state !== 2'd0)  begin n_bad++; $display("FAIL reset_state: got %0d expected 0", state); end
        @(posedge clk); #1 reset_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_cmp++;
            if (state !== 2'd0 || adv !== 1'b0) begin
                n_bad++; $display("FAIL idle_hold: got state=%0d adv=%b expected 0/0", state, adv);
            end
        end
        m_idx = '0;
    endtask

    task automatic test_run_lap();
        exp_t e;
        int   t0, last, n;
        @(posedge clk); #1 dir = 1'b1; rate = 2'd0; run = 1'b1; t0 = cyc;
        push_adv(DEPTH, 1'b1);
        n = 0; last = 0;
        for (int i = 0; i < 80 && sb.size() > 0; i++) begin
            @(negedge clk);
            if (adv === 1'b1) begin
                e = sb.pop_front();
                n_cmp++;
                if (index !== e.idx || wrap !== e.wr) begin
                    n_bad++; $display("FAIL run_seq: got index=%0d wrap=%b expected index=%0d wrap=%b", index, wrap, e.idx, e.wr);
                end
                n_cmp++;
                if (n == 0 && cyc !== t0 + 4) begin
                    n_bad++; $display("FAIL run_latency: got %0d cycles expected 4", cyc - t0);
                end else if (n > 0 && cyc !== last + 1) begin
                    n_bad++; $display("FAIL run_spacing: got %0d cycles expected 1", cyc - last);
                end
                last = cyc; n++;
            end
        end
        n_cmp++; if (sb.size() != 0) begin n_bad++; $display("FAIL run_timeout: got %0d pending expected 0", sb.size()); sb.delete(); end
        n_cmp++; if (laps !== 8'd1)  begin n_bad++; $display("FAIL run_laps: got %0d expected 1", laps); end
        n_cmp++; if (blank !== 1'b0 || state !== 2'd1) begin n_bad++; $display("FAIL run_state: got blank=%b state=%0d expected 0/1", blank, state); end
        // run drop takes two cycles to synchronize, so two more advances land first
        run = 1'b0;
        push_adv(2, 1'b1);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (adv === 1'b1) begin
                n_cmp++;
                if (sb.size() == 0) begin
                    n_bad++; $display("FAIL pause_extra_adv: got index=%0d expected no advance", index);
                end else begin
                    e = sb.pop_front();
                    if (index !== e.idx) begin n_bad++; $display("FAIL pause_seq: got %0d expected %0d", index, e.idx); end
                end
            end
        end
        n_cmp++; if (sb.size() != 0 || state !== 2'd2) begin n_bad++; $display("FAIL pause_state: got state=%0d pending=%0d expected 2/0", state, sb.size()); sb.delete(); end
    endtask

    task automatic test_step();
        exp_t e;
        int   t0;
        logic up;
        logic seen;
        for (int k = 0; k < 6; k++) begin
            up = (k < 3);
            @(posedge clk); #1 step = 1'b1; dir = up; t0 = cyc;
            push_adv(1, up);
            seen = 1'b0;
            for (int i = 1; i <= 7; i++) begin
                @(negedge clk);
                if (i == 2) step = 1'b0;
                if (cyc == t0 + 3) begin
                    n_cmp++; if (state !== 2'd3) begin n_bad++; $display("FAIL step_state: got %0d expected 3", state); end
                end
                if (adv === 1'b1) begin
                    n_cmp++;
                    if (sb.size() == 0) begin
                        n_bad++; $display("FAIL step_extra_adv: got index=%0d expected no advance", index);
                    end else begin
                        e = sb.pop_front(); seen = 1'b1;
                        if (index !== e.idx || cyc !== t0 + 4) begin
                            n_bad++; $display("FAIL step_adv: got index=%0d at +%0d expected index=%0d at +4", index, cyc - t0, e.idx);
                        end
                    end
                end
                if (cyc == t0 + 6) begin
                    n_cmp++; if (state !== 2'd2) begin n_bad++; $display("FAIL step_return: got %0d expected 2", state); end
                end
            end
            n_cmp++; if (!seen) begin n_bad++; $display("FAIL step_timeout: got no advance expected one"); sb.delete(); end
        end
    endtask

    task automatic test_rate();
        exp_t e;
        int   t0, last, n;
        @(posedge clk); #1 dir = 1'b1; rate = 2'd1; run = 1'b1;
        push_adv(4, 1'b1);
        n = 0; last = 0;
        for (int i = 0; i < 200 && sb.size() > 0; i++) begin
            @(negedge clk);
            if (adv === 1'b1) begin
                e = sb.pop_front();
                n_cmp++;
                if (index !== e.idx) begin n_bad++; $display("FAIL rate1_seq: got %0d expected %0d", index, e.idx); end
                if (n > 0) begin
                    n_cmp++; if (cyc - last != 16) begin n_bad++; $display("FAIL rate1_spacing: got %0d expected 16", cyc - last); end
                end
                if (n == 0) step = 1'b1;
                if (n == 1) step = 1'b0;
                last = cyc; n++;
            end
        end
        n_cmp++; if (sb.size() != 0) begin n_bad++; $display("FAIL rate1_timeout: got %0d pending expected 0", sb.size()); sb.delete(); end
        repeat (5) @(posedge clk);
        #1 rate = 2'd2; t0 = cyc;
        push_adv(1, 1'b1);
        for (int i = 0; i < 300 && sb.size() > 0; i++) begin
            @(negedge clk);
            if (adv === 1'b1) begin
                e = sb.pop_front();
                n_cmp++;
                if (index !== e.idx || cyc !== t0 + 257) begin
                    n_bad++; $display("FAIL rate2_switch: got index=%0d at +%0d expected index=%0d at +257", index, cyc - t0, e.idx);
                end
            end
        end
        n_cmp++; if (sb.size() != 0) begin n_bad++; $display("FAIL rate2_timeout: got %0d pending expected 0", sb.size()); sb.delete(); end
    endtask

    task automatic test_wrap_laps();
        exp_t e;
        int   n;
        @(posedge clk); #1 run = 1'b0; clr = 1'b1;
        repeat (5) @(negedge clk);
        n_cmp++; if (state !== 2'd0 || index !== '0 || blank !== 1'b1) begin n_bad++; $display("FAIL clr_idle: got state=%0d index=%0d blank=%b expected 0/0/1", state, index, blank); end
        @(posedge clk); #1 clr = 1'b0; dir = 1'b0; rate = 2'd0; run = 1'b1;
        m_idx = '0;
        push_adv(300 * DEPTH, 1'b0);
        n = 0;
        for (int i = 0; i < 12000 && sb.size() > 0; i++) begin
            @(negedge clk);
            if (adv === 1'b1) begin
                e = sb.pop_front(); n++;
                n_cmp++;
                if (index !== e.idx || wrap !== e.wr) begin
                    n_bad++; $display("FAIL down_seq: got index=%0d wrap=%b expected index=%0d wrap=%b (adv %0d)", index, wrap, e.idx, e.wr, n);
                end
                if (n == 1) begin
                    n_cmp++; if (laps !== 8'd1) begin n_bad++; $display("FAIL laps_first: got %0d expected 1", laps); end
                end
                if (n == 254 * DEPTH) begin
                    n_cmp++; if (laps !== 8'd254) begin n_bad++; $display("FAIL laps_254: got %0d expected 254", laps); end
                end
                if (n == 254 * DEPTH + 1) begin
                    n_cmp++; if (laps !== 8'd255) begin n_bad++; $display("FAIL laps_255: got %0d expected 255", laps); end
                end
            end
        end
        n_cmp++; if (sb.size() != 0) begin n_bad++; $display("FAIL laps_timeout: got %0d pending expected 0", sb.size()); sb.delete(); end
        run = 1'b0;
        push_adv(2, 1'b0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (adv === 1'b1) begin
                n_cmp++;
                if (sb.size() == 0) begin
                    n_bad++; $display("FAIL laps_extra_adv: got index=%0d expected no advance", index);
                end else begin
                    e = sb.pop_front();
                    if (index !== e.idx) begin n_bad++; $display("FAIL laps_tail: got %0d expected %0d", index, e.idx); end
                end
            end
        end
        n_cmp++; if (laps !== 8'd255 || state !== 2'd2) begin n_bad++; $display("FAIL laps_sat: got laps=%0d state=%0d expected 255/2", laps, state); end
        sb.delete();
    endtask

    task automatic test_clr();
        exp_t e;
        logic bad;
        @(posedge clk); #1 dir = 1'b1; run = 1'b1;
        push_adv(17, 1'b1);
        for (int i = 0; i < 40 && sb.size() > 0; i++) begin
            @(negedge clk);
            if (adv === 1'b1) begin
                e = sb.pop_front();
                n_cmp++;
                if (index !== e.idx || wrap !== e.wr) begin n_bad++; $display("FAIL clr_lead: got index=%0d wrap=%b expected index=%0d wrap=%b", index, wrap, e.idx, e.wr); end
            end
        end
        n_cmp++; if (sb.size() != 0 || laps !== 8'd255) begin n_bad++; $display("FAIL clr_lead_end: got pending=%0d laps=%0d expected 0/255", sb.size(), laps); sb.delete(); end
        // clr and step arrive together; the index still reaches 17 before clr is synchronized
        clr = 1'b1; step = 1'b1; run = 1'b0;
        push_adv(2, 1'b1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (adv === 1'b1) begin
                n_cmp++;
                if (sb.size() == 0) begin
                    n_bad++; $display("FAIL clr_extra_adv: got index=%0d expected no advance", index);
                end else begin
                    e = sb.pop_front();
                    if (index !== e.idx) begin n_bad++; $display("FAIL clr_tail: got %0d expected %0d", index, e.idx); end
                end
            end
        end
        n_cmp++; if (sb.size() != 0) begin n_bad++; $display("FAIL clr_tail_missing: got %0d pending expected 0", sb.size()); sb.delete(); end
        n_cmp++; if (index !== '0 || laps !== 8'd0) begin n_bad++; $display("FAIL clr_regs: got index=%0d laps=%0d expected 0/0", index, laps); end
        n_cmp++; if (state !== 2'd0 || blank !== 1'b1 || adv !== 1'b0) begin n_bad++; $display("FAIL clr_state: got state=%0d blank=%b adv=%b expected 0/1/0", state, blank, adv); end
        @(negedge clk); step = 1'b0;
        repeat (3) @(negedge clk);
        clr = 1'b0;
        bad = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (state !== 2'd0 || adv !== 1'b0) bad = 1'b1;
        end
        n_cmp++; if (bad) begin n_bad++; $display("FAIL clr_step_ignored: got state=%0d adv=%b expected 0/0", state, adv); end
        m_idx = '0;
    endtask

    task automatic test_async_reset();
        exp_t e;
        int   t0;
        @(posedge clk); #1 dir = 1'b1; rate = 2'd0; run = 1'b1;
        push_adv(10, 1'b1);
        for (int i = 0; i < 30 && sb.size() > 0; i++) begin
            @(negedge clk);
            if (adv === 1'b1) begin
                e = sb.pop_front();
                n_cmp++;
                if (index !== e.idx) begin n_bad++; $display("FAIL ares_lead: got %0d expected %0d", index, e.idx); end
            end
        end
        n_cmp++; if (sb.size() != 0) begin n_bad++; $display("FAIL ares_timeout: got %0d pending expected 0", sb.size()); sb.delete(); end
        #2 reset_n = 1'b0;
        #1;
        n_cmp++; if (index !== '0 || adv !== 1'b0 || wrap !== 1'b0) begin n_bad++; $display("FAIL ares_out: got index=%0d adv=%b wrap=%b expected 0/0/0", index, adv, wrap); end
        n_cmp++; if (state !== 2'd0 || blank !== 1'b1 || laps !== 8'd0) begin n_bad++; $display("FAIL ares_state: got state=%0d blank=%b laps=%0d expected 0/1/0", state, blank, laps); end
        m_idx = '0;
        @(posedge clk); #1 reset_n = 1'b1; t0 = cyc;
        push_adv(1, 1'b1);
        for (int i = 0; i < 8 && sb.size() > 0; i++) begin
            @(negedge clk);
            if (adv === 1'b1) begin
                e = sb.pop_front();
                n_cmp++;
                if (index !== e.idx || cyc !== t0 + 4) begin
                    n_bad++; $display("FAIL ares_resync: got index=%0d at +%0d expected index=%0d at +4", index, cyc - t0, e.idx);
                end
            end
        end
        n_cmp++; if (sb.size() != 0) begin n_bad++; $display("FAIL ares_resync_timeout: got %0d pending expected 0", sb.size()); sb.delete(); end
        run = 1'b0;
    endtask

    initial begin
        test_reset();
        test_run_lap();
        test_step();
        test_rate();
        test_wrap_laps();
        test_clr();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got no completion expected finish before 3 ms");
        $fatal(1, "watchdog expired");
    end

endmodule
